// File: rtl/tpu_pkg.sv
// Shared tpu host-interface definitions: opcodes, instruction layout, default array geometry.
package tpu_pkg;

  localparam int OPCODE_W = 3;
  localparam int IMM_W    = 29;
  localparam int INSTR_W  = OPCODE_W + IMM_W;

  localparam int TPU_N    = 4;
  localparam int TPU_DW   = 8;
  localparam int TPU_ACCW = 32;

  typedef enum logic [OPCODE_W-1:0] {
    NOP               = 3'd0,
    READ_HOST_MEMORY  = 3'd1,
    READ_WEIGHTS      = 3'd2,
    MATRIX_MULTIPLY   = 3'd3,
    WRITE_HOST_MEMORY = 3'd4
  } tpu_instruction_e;

  typedef struct packed {
    tpu_instruction_e   opcode;
    logic [IMM_W-1:0]   imm;
  } tpu_instr_t;

  function automatic logic [INSTR_W-1:0] make_instr(input tpu_instruction_e op);
    tpu_instr_t w;
    w.opcode = op;
    w.imm    = '0;
    return w;
  endfunction

endpackage

// File: rtl/seq_stream_pusher.sv
// Streams N*N source elements to the tpu: one read, one strobe a cycle later, then WR_GAP idle cycles.
module seq_stream_pusher
  import tpu_pkg::*;
#(
  parameter int N      = TPU_N,
  parameter int DW     = TPU_DW,
  parameter int SRC_AW = 12,
  parameter int WR_GAP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [SRC_AW-1:0] base_i,
  input  logic [DW-1:0]     src_rd_data_i,
  output logic              src_rd_en_o,
  output logic [SRC_AW-1:0] src_addr_o,
  output logic [DW-1:0]     wdata_o,
  output logic              wvalid_o,
  output logic [11:0]       waddr_o,
  output logic              done_o
);

  localparam int          GW       = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;
  localparam logic [11:0] LAST_IDX = 12'(N * N - 1);

  logic          run_q, run_d;
  logic [11:0]   idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          wvalid_q;
  logic [11:0]   waddr_q;
  logic          last_q;
  logic          rd_en;

  assign rd_en = run_q && (gap_q == '0);

  always_comb begin
    run_d = run_q;
    idx_d = idx_q;
    gap_d = gap_q;
    if (start_i) begin
      run_d = 1'b1;
      idx_d = '0;
      gap_d = '0;
    end else if (rd_en) begin
      if (idx_q == LAST_IDX) begin
        run_d = 1'b0;
        gap_d = '0;
      end else begin
        idx_d = idx_q + 12'd1;
        gap_d = GW'(WR_GAP);
      end
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q    <= 1'b0;
      idx_q    <= '0;
      gap_q    <= '0;
      wvalid_q <= 1'b0;
      waddr_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      run_q    <= run_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      wvalid_q <= rd_en;
      waddr_q  <= idx_q;
      last_q   <= rd_en && (idx_q == LAST_IDX);
    end
  end

  // Source data arrives the cycle after the read, so it is forwarded straight through.
  assign src_rd_en_o = rd_en;
  assign src_addr_o  = rd_en ? (base_i + SRC_AW'(idx_q)) : '0;
  assign wvalid_o    = wvalid_q;
  assign wdata_o     = wvalid_q ? src_rd_data_i : '0;
  assign waddr_o     = wvalid_q ? waddr_q : '0;
  assign done_o      = wvalid_q && last_q;

endmodule

// File: rtl/tpu_host_sequencer.sv
// Host-side job sequencer: loads weights once, then per tile loads activations, multiplies, captures results.
// IDLE: wait start | ISSUE_W/ISSUE_A/ISSUE_MM: hold opcode until ready | PUSH_W/PUSH_A: stream N*N elements
// WAIT_DONE: wait mmu_done or time out | CAPTURE: write N accumulator columns
module tpu_host_sequencer
  import tpu_pkg::*;
#(
  parameter int N       = TPU_N,
  parameter int DW      = TPU_DW,
  parameter int ACCW    = TPU_ACCW,
  parameter int SRC_AW  = 12,
  parameter int RES_AW  = 10,
  parameter int WR_GAP  = 1,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          num_tiles,
  output logic                busy,
  output logic                job_done,
  output logic                timeout_err,
  output logic                src_rd_en,
  output logic [SRC_AW-1:0]   src_addr,
  input  logic [DW-1:0]       src_rd_data,
  output logic                host_instruction_valid,
  output logic [31:0]         host_instruction,
  input  logic                host_instruction_ready,
  output logic [DW-1:0]       host_write_data,
  output logic                host_wdata_valid,
  output logic [11:0]         host_write_address,
  input  logic                mmu_done,
  input  logic [N*ACCW-1:0]   acc_row,
  output logic                res_wr_en,
  output logic [RES_AW-1:0]   res_wr_addr,
  output logic [ACCW-1:0]     res_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_W, S_PUSH_W, S_ISSUE_A, S_PUSH_A, S_ISSUE_MM, S_WAIT_DONE, S_CAPTURE
  } seq_state_e;

  localparam int                TW      = $clog2(TIMEOUT + 1);
  localparam int                CW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [SRC_AW-1:0] TILE_SZ = SRC_AW'(N * N);

  seq_state_e          state_q, state_d;
  logic [7:0]          tiles_q, tiles_d;
  logic [7:0]          tile_q, tile_d;
  logic [TW-1:0]       wait_q, wait_d;
  logic [CW-1:0]       col_q, col_d;
  logic [N*ACCW-1:0]   acc_q, acc_d;
  logic [SRC_AW-1:0]   src_base_q, src_base_d;
  logic [RES_AW-1:0]   res_addr_q, res_addr_d;
  logic                terr_q, terr_d;
  logic                done_q, done_d;

  logic                push_start, push_done;
  logic [SRC_AW-1:0]   push_base;
  logic                instr_valid;
  tpu_instruction_e    instr_op;

  always_comb begin
    state_d     = state_q;
    tiles_d     = tiles_q;
    tile_d      = tile_q;
    wait_d      = wait_q;
    col_d       = col_q;
    acc_d       = acc_q;
    src_base_d  = src_base_q;
    res_addr_d  = res_addr_q;
    terr_d      = terr_q;
    done_d      = 1'b0;
    push_start  = 1'b0;
    instr_valid = 1'b0;
    instr_op    = NOP;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_tiles != 8'd0) begin
            terr_d     = 1'b0;
            tiles_d    = num_tiles;
            tile_d     = '0;
            src_base_d = TILE_SZ;
            res_addr_d = '0;
            state_d    = S_ISSUE_W;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ISSUE_W: begin
        instr_valid = 1'b1;
        instr_op    = READ_WEIGHTS;
        if (host_instruction_ready) begin
          push_start = 1'b1;
          state_d    = S_PUSH_W;
        end
      end
      S_PUSH_W: if (push_done) state_d = S_ISSUE_A;
      S_ISSUE_A: begin
        instr_valid = 1'b1;
        instr_op    = READ_HOST_MEMORY;
        if (host_instruction_ready) begin
          push_start = 1'b1;
          state_d    = S_PUSH_A;
        end
      end
      S_PUSH_A: if (push_done) state_d = S_ISSUE_MM;
      S_ISSUE_MM: begin
        instr_valid = 1'b1;
        instr_op    = MATRIX_MULTIPLY;
        if (host_instruction_ready) begin
          wait_d  = TW'(TIMEOUT - 1);
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (mmu_done) begin
          acc_d   = acc_row;
          col_d   = '0;
          state_d = S_CAPTURE;
        end else if (wait_q == '0) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q - TW'(1);
        end
      end
      S_CAPTURE: begin
        res_addr_d = res_addr_q + RES_AW'(1);
        if (col_q == CW'(N - 1)) begin
          if (tile_q == tiles_q - 8'd1) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Weights stay resident in the array; only the next activation tile is loaded.
            tile_d     = tile_q + 8'd1;
            src_base_d = src_base_q + TILE_SZ;
            state_d    = S_ISSUE_A;
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tiles_q    <= '0;
      tile_q     <= '0;
      wait_q     <= '0;
      col_q      <= '0;
      acc_q      <= '0;
      src_base_q <= '0;
      res_addr_q <= '0;
      terr_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tiles_q    <= tiles_d;
      tile_q     <= tile_d;
      wait_q     <= wait_d;
      col_q      <= col_d;
      acc_q      <= acc_d;
      src_base_q <= src_base_d;
      res_addr_q <= res_addr_d;
      terr_q     <= terr_d;
      done_q     <= done_d;
    end
  end

  assign push_base = (state_q == S_PUSH_W) ? '0 : src_base_q;

  seq_stream_pusher #(
    .N      (N),
    .DW     (DW),
    .SRC_AW (SRC_AW),
    .WR_GAP (WR_GAP)
  ) u_pusher (
    .clk           (clk),
    .reset         (reset),
    .start_i       (push_start),
    .base_i        (push_base),
    .src_rd_data_i (src_rd_data),
    .src_rd_en_o   (src_rd_en),
    .src_addr_o    (src_addr),
    .wdata_o       (host_write_data),
    .wvalid_o      (host_wdata_valid),
    .waddr_o       (host_write_address),
    .done_o        (push_done)
  );

  assign busy                   = (state_q != S_IDLE);
  assign job_done               = done_q;
  assign timeout_err            = terr_q;
  assign host_instruction_valid = instr_valid;
  assign host_instruction       = instr_valid ? make_instr(instr_op) : '0;
  assign res_wr_en              = (state_q == S_CAPTURE);
  assign res_wr_addr            = res_wr_en ? res_addr_q : '0;
  assign res_wr_data            = res_wr_en ? acc_q[int'(col_q)*ACCW +: ACCW] : '0;

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Scoreboard bench: source memory and tpu models, expected results from plain matrix arithmetic.
module tb_tpu_host_sequencer;
  import tpu_pkg::*;

  localparam int N = 4, DW = 8, ACCW = 32, SRC_AW = 12, RES_AW = 10, WR_GAP = 1, TIMEOUT = 16;
  localparam int NN = N * N;
  localparam int SHOW_ROW = 3;

  logic                clk, reset, start;
  logic [7:0]          num_tiles;
  logic                busy, job_done, timeout_err;
  logic                src_rd_en;
  logic [SRC_AW-1:0]   src_addr;
  logic [DW-1:0]       src_rd_data;
  logic                host_instruction_valid;
  logic [31:0]         host_instruction;
  logic                host_instruction_ready;
  logic [DW-1:0]       host_write_data;
  logic                host_wdata_valid;
  logic [11:0]         host_write_address;
  logic                mmu_done;
  logic [N*ACCW-1:0]   acc_row;
  logic                res_wr_en;
  logic [RES_AW-1:0]   res_wr_addr;
  logic [ACCW-1:0]     res_wr_data;

  tpu_host_sequencer #(
    .N(N), .DW(DW), .ACCW(ACCW), .SRC_AW(SRC_AW), .RES_AW(RES_AW), .WR_GAP(WR_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles),
    .busy(busy), .job_done(job_done), .timeout_err(timeout_err),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rd_data(src_rd_data),
    .host_instruction_valid(host_instruction_valid), .host_instruction(host_instruction),
    .host_instruction_ready(host_instruction_ready),
    .host_write_data(host_write_data), .host_wdata_valid(host_wdata_valid),
    .host_write_address(host_write_address),
    .mmu_done(mmu_done), .acc_row(acc_row),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- models and scoreboard state ----------------
  logic [7:0]                 src_mem [0:4095];
  logic [31:0]                exp_instr_q [$];
  logic [RES_AW+ACCW-1:0]     exp_res_q [$];
  logic [31:0]                wt [0:NN-1];
  logic [31:0]                act [0:NN-1];

  int  rdy_mode = 0;
  int  bp_cnt = 0;
  bit  never_done = 0, spur_en = 0, mm_pend = 0, load_w = 0;
  int  mm_cnt = 0, ew_idx = 0, exp_src = 0, n_ra = 0, cyc = 0, last_strobe = 0;
  int  n_instr = 0, n_rd = 0, n_strobe = 0, n_astrobe = 0, n_res = 0, n_done = 0, n_stall = 0, wait_cyc = 0;
  logic        prev_valid = 0, prev_ready = 0;
  logic [31:0] prev_instr = 0;

  always @(posedge clk) if (src_rd_en) src_rd_data <= src_mem[src_addr];

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) host_instruction_ready = 1'b1;
    else if (rdy_mode == 1) host_instruction_ready = ($urandom_range(0, 2) != 0);
    else if (host_instruction_valid) begin
      if (bp_cnt < 5) begin host_instruction_ready = 1'b0; bp_cnt++; end
      else host_instruction_ready = 1'b1;
    end else begin
      bp_cnt = 0;
      host_instruction_ready = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [31:0] e, s;
    logic [RES_AW+ACCW-1:0] r;
    cyc++;
    // tpu: garbage on acc_row except in the single mmu_done cycle
    mmu_done = 1'b0;
    for (int c = 0; c < N; c++) acc_row[c*ACCW +: ACCW] = $urandom;
    if (mm_pend) begin
      if (busy) wait_cyc++;
      if (!never_done) begin
        mm_cnt--;
        if (mm_cnt == 0) begin
          mm_pend = 0;
          mmu_done = 1'b1;
          for (int c = 0; c < N; c++) begin
            s = 0;
            for (int k = 0; k < N; k++) s += act[SHOW_ROW*N + k] * wt[k*N + c];
            acc_row[c*ACCW +: ACCW] = s;
          end
        end
      end
    end else if (spur_en && $urandom_range(0, 7) == 0) mmu_done = 1'b1;

    if (reset) prev_valid = 0;
    else begin
      if (host_instruction_valid && prev_valid && !prev_ready)
        chk("instr_stable", host_instruction, prev_instr);
      if (host_instruction_valid && !host_instruction_ready) n_stall++;
      if (host_instruction_valid && host_instruction_ready) begin
        n_instr++;
        if (exp_instr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL instr_unexpected actual=%0h required=none", host_instruction);
        end else begin
          e = exp_instr_q.pop_front();
          chk("instr_word", host_instruction, e);
        end
        if (host_instruction[31:29] == READ_WEIGHTS) begin
          load_w = 1; ew_idx = 0; exp_src = 0;
        end else if (host_instruction[31:29] == READ_HOST_MEMORY) begin
          load_w = 0; ew_idx = 0; n_ra++; exp_src = n_ra * NN;
        end else if (host_instruction[31:29] == MATRIX_MULTIPLY) begin
          mm_pend = 1; mm_cnt = $urandom_range(1, 6);
        end
      end
      prev_valid = host_instruction_valid;
      prev_ready = host_instruction_ready;
      prev_instr = host_instruction;

      if (src_rd_en) begin
        n_rd++;
        chk("src_addr", src_addr, exp_src);
        exp_src++;
      end
      if (host_wdata_valid) begin
        chk("wr_addr", host_write_address, ew_idx);
        if (ew_idx > 0) chk("wr_spacing", cyc - last_strobe, 1 + WR_GAP);
        last_strobe = cyc;
        if (load_w) wt[ew_idx % NN] = 32'(host_write_data);
        else begin
          n_astrobe++;
          if (host_write_address < NN) act[host_write_address] = 32'(host_write_data);
        end
        ew_idx++;
        n_strobe++;
      end
      if (res_wr_en) begin
        n_res++;
        if (exp_res_q.size() == 0) begin
          total++; bad++;
          $display("FAIL res_unexpected actual=%0h/%0h required=none", res_wr_addr, res_wr_data);
        end else begin
          r = exp_res_q.pop_front();
          chk("res_addr_data", {res_wr_addr, res_wr_data}, r);
        end
      end
      if (job_done) n_done++;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [ACCW-1:0] ref_acc(input int t, input int c);
    logic [ACCW-1:0] s = 0;
    for (int k = 0; k < N; k++)
      s += ACCW'(src_mem[(t + 1)*NN + SHOW_ROW*N + k]) * ACCW'(src_mem[k*N + c]);
    return s;
  endfunction

  task automatic clear_sb();
    exp_instr_q.delete();
    exp_res_q.delete();
    mm_pend = 0;
    n_ra = 0; n_instr = 0; n_rd = 0; n_strobe = 0; n_astrobe = 0;
    n_res = 0; n_done = 0; n_stall = 0; wait_cyc = 0;
  endtask

  task automatic expect_job(input int nt, input bit to);
    if (nt > 0) begin
      exp_instr_q.push_back(make_instr(READ_WEIGHTS));
      for (int t = 0; t < nt; t++) begin
        exp_instr_q.push_back(make_instr(READ_HOST_MEMORY));
        exp_instr_q.push_back(make_instr(MATRIX_MULTIPLY));
        if (!to)
          for (int c = 0; c < N; c++)
            exp_res_q.push_back({RES_AW'(t*N + c), ref_acc(t, c)});
      end
    end
  endtask

  task automatic pulse_start(input int nt);
    @(posedge clk); #1;
    start = 1'b1; num_tiles = 8'(nt);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    chk(name, |{busy, job_done, timeout_err, src_rd_en, src_addr, host_instruction_valid,
                host_instruction, host_write_data, host_wdata_valid, host_write_address,
                res_wr_en, res_wr_addr, res_wr_data}, 0);
  endtask

  task automatic run_job(input int nt, input bit to);
    int i;
    clear_sb();
    expect_job(nt, to);
    pulse_start(nt);
    if (nt == 0) chk("zero_tiles_done", job_done, 1);
    else begin
      chk("busy_after_start", busy, 1);
      chk("timeout_err_cleared", timeout_err, 0);
    end
    for (i = 0; i < 3000 && busy; i++) begin @(posedge clk); #1; end
    if (busy) begin
      total++; bad++;
      $display("FAIL job_stuck busy=1 required=0");
      do_reset();
    end
    repeat (2) @(negedge clk);
    chk("job_done_count", n_done, to ? 0 : 1);
    chk("instr_left", exp_instr_q.size(), 0);
    chk("res_left", exp_res_q.size(), 0);
    chk("res_count", n_res, to ? 0 : nt*N);
    chk("strobe_count", n_strobe, (nt == 0) ? 0 : (to ? 2*NN : NN*(nt + 1)));
    if (to) begin
      chk("timeout_err_set", timeout_err, 1);
      chk("wait_cycles", wait_cyc, TIMEOUT);
    end else chk("timeout_err_low", timeout_err, 0);
    if (rdy_mode == 2) chk("stall_cycles", n_stall, (nt == 0) ? 0 : 5*(1 + 2*nt));
    if (nt == 0) chk("zero_tiles_quiet", n_instr + n_rd, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int nt;
    reset = 1'b1; start = 1'b0; num_tiles = 8'd0;
    host_instruction_ready = 1'b1; mmu_done = 1'b0; acc_row = '0; src_rd_data = '0;
    for (int a = 0; a < 4096; a++) src_mem[a] = 8'd0;
    for (int a = 0; a < NN; a++) begin wt[a] = 0; act[a] = 0; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_outputs_zero("reset_outputs");

    // nominal: weights rows 1..4, tile 0 = 1..16, tile 1 = tile 0 + 1
    for (int k = 0; k < N; k++)
      for (int c = 0; c < N; c++) src_mem[k*N + c] = 8'(k + 1);
    for (int a = 0; a < NN; a++) begin
      src_mem[NN + a]   = 8'(a + 1);
      src_mem[2*NN + a] = 8'(a + 2);
    end
    chk("nominal_ref_row3", ref_acc(0, 0), 150);
    rdy_mode = 0;
    run_job(1, 0);

    rdy_mode = 2;
    run_job(1, 0);

    rdy_mode = 0;
    run_job(2, 0);

    run_job(0, 0);

    never_done = 1;
    run_job(1, 1);
    never_done = 0;
    repeat (3) @(posedge clk);
    #1 chk("timeout_err_sticky", timeout_err, 1);

    // reset in the middle of the activation push
    clear_sb();
    expect_job(1, 0);
    pulse_start(1);
    for (int i = 0; i < 2000 && n_astrobe < 7; i++) @(negedge clk);
    chk("reached_push_a", n_astrobe >= 7, 1);
    do_reset();
    check_outputs_zero("midjob_reset_outputs");
    chk("midjob_reset_busy", busy, 0);
    run_job(1, 0);

    spur_en = 1;
    for (int j = 0; j < 8; j++) begin
      for (int a = 0; a < 4*NN; a++) src_mem[a] = 8'($urandom);
      nt = $urandom_range(1, 3);
      rdy_mode = $urandom_range(0, 2);
      run_job(nt, 0);
    end
    spur_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tpu_host_sequencer.md
Name: tpu_host_sequencer

Overview:
- Synthesizable host-side sequencer. Loads one weight matrix and NUM_TILES activation tiles from a source buffer into the tpu, issues the opcodes, and captures every accumulator result.
- Replaces hand-driven host stimulus. Sits between a source SRAM or result SRAM and the tpu host port.
- Generalises the single-matmul flow with parametric N/DW, back-to-back tiles, instruction backpressure, and a done-timeout.

Parameters:
- N, 4, systolic array dimension (N×N tile)
- DW, 8, weight/activation element width
- ACCW, 32, accumulator element width
- SRC_AW, 12, source buffer address width
- RES_AW, 10, result buffer address width
- WR_GAP, 1, idle cycles inserted after each host_wdata_valid pulse
- TIMEOUT, 256, max cycles waiting for mmu_done

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a job when idle
- num_tiles  in  8  activation tiles in this job (0 = no-op)
- busy  out  1  job in progress
- job_done  out  1  one-cycle pulse at successful end
- timeout_err  out  1  sticky until next start; mmu_done not seen within TIMEOUT
- src_rd_en  out  1  source read strobe
- src_addr  out  SRC_AW  source address; weights at 0..N*N-1, tile t at (t+1)*N*N..
- src_rd_data  in  DW  valid exactly 1 cycle after src_rd_en
- host_instruction_valid  out  1  instruction valid
- host_instruction  out  32  {opcode[2:0], imm[28:0]}, imm = 0
- host_instruction_ready  in  1  tpu accepts instruction
- host_write_data  out  DW  element to tpu
- host_wdata_valid  out  1  element strobe
- host_write_address  out  12  element index within tile (row-major)
- mmu_done  in  1  tpu multiply complete
- acc_row  in  N*ACCW  tpu accumulator row, col 0 in LSBs
- res_wr_en  out  1  result write strobe
- res_wr_addr  out  RES_AW  tile*N + col
- res_wr_data  out  ACCW  captured accumulator element

Behaviour:
- Reset (sync, active-high) forces state IDLE. All outputs drop to 0, including timeout_err. All counters clear. Reset wins over any in-flight activity at that edge.
- IDLE: start with num_tiles>0 clears timeout_err and goes to ISSUE_W. start with num_tiles=0 pulses job_done the next cycle and stays IDLE. start while busy is ignored.
- Instruction states:
  - ISSUE_W issues READ_WEIGHTS. ISSUE_A issues READ_HOST_MEMORY. ISSUE_MM issues MATRIX_MULTIPLY.
  - host_instruction_valid stays high, with stable payload, until a clk edge where host_instruction_ready=1. The transfer completes on that edge and valid drops on the next cycle.
- PUSH_W/PUSH_A stream N*N elements in row-major order, indices 0..N*N-1:
  - Read issued in cycle c. host_wdata_valid=1 with the data in c+1. Then WR_GAP idle cycles follow.
  - One element per 1+WR_GAP cycles.
  - host_write_address = element index. In PUSH_W it is also driven, and the tpu ignores it.
- Order per tile: ISSUE_A → PUSH_A → ISSUE_MM → WAIT_DONE → CAPTURE.
- WAIT_DONE: a cycle counter starts at 0. If mmu_done=1, go to CAPTURE and register acc_row that cycle. If the counter reaches TIMEOUT, set timeout_err, drop busy, and go to IDLE with no job_done.
- CAPTURE: N consecutive cycles, res_wr_en=1, res_wr_addr=tile*N+col, col 0..N-1. Then:
  - If more tiles remain, go to ISSUE_A. The weights are reused and not reloaded.
  - Otherwise pulse job_done and go to IDLE.
- busy=1 in every state except IDLE.
- mmu_done outside WAIT_DONE is ignored.
- Tile counter is 8-bit; res_wr_addr wraps modulo 2^RES_AW.
- src_addr arithmetic is SRC_AW-wide and wraps. Integrators size num_tiles so that (num_tiles+1)*N*N ≤ 2^SRC_AW.

Decomposition:
- Shared package tpu_pkg holds:
  - tpu_instruction_e (READ_HOST_MEMORY, READ_WEIGHTS, MATRIX_MULTIPLY, …) and its OPCODE_W=3
  - default N, DW, ACCW
  - the 32-bit instruction layout
- Sequencer FSM enum is local.
- One sub-module: seq_stream_pusher. It runs the N*N read/strobe/gap counter and is shared by PUSH_W and PUSH_A. Its handshake is start/done.

Test Plan:
- Nominal, N=4, num_tiles=1, ready tied 1:
  - Source holds weights B rows {1,1,1,1},{2,…},{3,…},{4,…}. Tile 0 is A = 1..16 row-major. A tpu model asserts mmu_done.
  - Required: res addr 0..3 = acc_row. With the tpu showing row 3, that is 150,150,150,150. job_done pulses once.
  - Required: exactly 16+16 wdata strobes, spaced 2 cycles apart.
- Backpressure: ready held 0 for 5 cycles on each opcode → valid and payload held stable for those cycles, with exactly one transfer per opcode. The final result is unchanged.
- Multi-tile, num_tiles=2 (tile 1 = A+1):
  - Required: READ_WEIGHTS issued once and READ_HOST_MEMORY twice.
  - Required: results written at addresses 0..7 in order.
- Timeout, TIMEOUT=16, mmu_done never asserted → timeout_err=1 at the 16th WAIT_DONE cycle, then IDLE, no job_done, no res_wr_en. The next start clears timeout_err.
- Reset mid-PUSH_A (after 7 elements) → the next cycle has all outputs 0 and busy=0. A fresh start replays the full sequence from READ_WEIGHTS.
- start with num_tiles=0 → job_done pulses one cycle later, with no instruction or src_rd_en activity.
